// File: rtl/controle_multiplicador_if.sv
// -----------------------------------------------------------------------------
// controle_multiplicador_if
// Bundles the start/operand/result signals of the shift-and-add multiplier
// controller together with its link to the external combinational Adder.
//
// Signals:
//   Iniciar         start request (wrapper -> controller)
//   MultiplicandoA  multiplicand  (wrapper -> controller)
//   MultiplicadorB  multiplier    (wrapper -> controller)
//   Soma            Adder sum, LARGURA+1 bits (Adder -> controller)
//   OperandoA       Adder operand A = accumulator (controller -> Adder)
//   OperandoB       Adder operand B = multiplicand or 0 (controller -> Adder)
//   Produto         registered 2*LARGURA product
//   Pronto          one-cycle completion pulse
//   Ocupado         high while an operation is in progress
//   Erro            (only with MULTIPLICADOR_ERRO_EN) start-while-busy pulse
//
// Modports: master = wrapper/Adder side, slave = controller side.
// -----------------------------------------------------------------------------
interface controle_multiplicador_if #(
  parameter int LARGURA = 4
) ();
  logic                   Iniciar;
  logic [LARGURA-1:0]     MultiplicandoA;
  logic [LARGURA-1:0]     MultiplicadorB;
  logic [LARGURA:0]       Soma;
  logic [LARGURA-1:0]     OperandoA;
  logic [LARGURA-1:0]     OperandoB;
  logic [2*LARGURA-1:0]   Produto;
  logic                   Pronto;
  logic                   Ocupado;
`ifdef MULTIPLICADOR_ERRO_EN
  logic                   Erro;
`endif

  modport master (
    output Iniciar, MultiplicandoA, MultiplicadorB, Soma,
    input  OperandoA, OperandoB, Produto, Pronto, Ocupado
`ifdef MULTIPLICADOR_ERRO_EN
    , input Erro
`endif
  );

  modport slave (
    input  Iniciar, MultiplicandoA, MultiplicadorB, Soma,
    output OperandoA, OperandoB, Produto, Pronto, Ocupado
`ifdef MULTIPLICADOR_ERRO_EN
    , output Erro
`endif
  );
endinterface

// File: rtl/controle_multiplicador.sv
// -----------------------------------------------------------------------------
// controle_multiplicador
// Sequential shift-and-add controller computing an unsigned LARGURA x LARGURA
// product with a single shared external combinational Adder. Each of the
// LARGURA iterations takes two cycles: SOMA captures {C,A} <- Soma, DESLOCA
// shifts {C,A,Q} right by one. The result is loaded into Produto on the last
// shift and Pronto is high for the following single cycle (state FIM).
//
// Ports:
//   Clock  rising-edge clock
//   Reset  synchronous, active-high; aborts any running operation
//   bus    controle_multiplicador_if.slave (start/operands, Adder link,
//          Produto/Pronto/Ocupado)
//
// Optional feature: define MULTIPLICADOR_ERRO_EN to add the registered Erro
// output, pulsing one cycle after Iniciar was seen while busy.
// -----------------------------------------------------------------------------
module controle_multiplicador #(
  parameter int LARGURA = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  controle_multiplicador_if.slave bus
);

  localparam int CW = $clog2(LARGURA) + 1;
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    SOMA    = 2'd1,
    DESLOCA = 2'd2,
    FIM     = 2'd3
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [LARGURA-1:0]     m_q, m_d;
  logic [LARGURA-1:0]     q_q, q_d;
  logic [LARGURA-1:0]     a_q, a_d;
  logic                   c_q, c_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2*LARGURA-1:0]   produto_q, produto_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q  <= OCIOSO;
      m_q       <= '0;
      q_q       <= '0;
      a_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      produto_q <= '0;
    end else begin
      estado_q  <= estado_d;
      m_q       <= m_d;
      q_q       <= q_d;
      a_q       <= a_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      produto_q <= produto_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    m_d       = m_q;
    q_d       = q_q;
    a_d       = a_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    produto_d = produto_q;

    case (estado_q)
      OCIOSO: begin
        if (bus.Iniciar) begin
          m_d      = bus.MultiplicandoA;
          q_d      = bus.MultiplicadorB;
          a_d      = '0;
          c_d      = 1'b0;
          cnt_d    = '0;
          estado_d = SOMA;
        end
      end

      SOMA: begin
        // With Q[0]=0 the Adder sees B=0, so this reloads A and clears C.
        {c_d, a_d} = bus.Soma;
        estado_d   = DESLOCA;
      end

      DESLOCA: begin
        // {C,A,Q} >> 1: the carry becomes the accumulator MSB and the
        // accumulator LSB moves into the multiplier register.
        a_d   = {c_q, a_q[LARGURA-1:1]};
        q_d   = {a_q[0], q_q[LARGURA-1:1]};
        c_d   = 1'b0;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == ULTIMO) begin
          produto_d = {c_q, a_q, q_q[LARGURA-1:1]};
          estado_d  = FIM;
        end else begin
          estado_d  = SOMA;
        end
      end

      FIM: begin
        estado_d = OCIOSO;
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign bus.OperandoA = a_q;
  assign bus.OperandoB = q_q[0] ? m_q : '0;
  assign bus.Produto   = produto_q;
  assign bus.Pronto    = (estado_q == FIM);
  assign bus.Ocupado   = (estado_q != OCIOSO);

`ifdef MULTIPLICADOR_ERRO_EN
  logic erro_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      erro_q <= 1'b0;
    end else begin
      erro_q <= bus.Iniciar & (estado_q != OCIOSO);
    end
  end

  assign bus.Erro = erro_q;
`endif

endmodule
